// File: rtl/tx_egress_pkg.sv
// Shared types and widths for the TX egress path: FSM encoding, channel ids, word widths.
package tx_egress_pkg;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic CH_D0 = 1'b0;
    localparam logic CH_D1 = 1'b1;

endpackage

// File: rtl/pop_skid_buf.sv
// Small circular FIFO holding popped words (tag + data) until the sink accepts them.
module pop_skid_buf #(
    parameter  int WIDTH = 7,
    parameter  int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             RESET_L,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic                        do_pop, do_push;

    // Pointers wrap explicitly since DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != OCC_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            assert (!(push && !pop && occ == OCC_W'(DEPTH)));
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/d_pop_arbiter.sv
// Round-robin pop arbiter for the D0/D1 FIFOs, feeding a skid buffer with a valid/ready
// sink, plus per-channel delivered-word counters and an idle flag.
module d_pop_arbiter #(
    parameter int DATA_W    = tx_egress_pkg::DATA_W,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = tx_egress_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic              D0_empty,
    input  logic              D1_empty,
    input  logic [DATA_W-1:0] D0_data_out,
    input  logic [DATA_W-1:0] D1_data_out,
    input  logic              sink_ready,
    output logic              POP_D0,
    output logic              POP_D1,
    output logic [DATA_W-1:0] data_out,
    output logic              dest_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  cnt_d0,
    output logic [CNT_W-1:0]  cnt_d1,
    output logic              idle
);
    import tx_egress_pkg::*;

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    state_t           state, state_nxt;
    logic             rr, inflight, idle_cond, deq, flush;
    logic             run, room, pop_go, gnt_d1;
    logic [OCC_W-1:0] occ;
    logic [DATA_W:0]  head, cap_data;

    // The pop strobe is itself the in-flight marker: the FIFO word is captured at the
    // edge that closes the strobe cycle.
    assign inflight  = POP_D0 | POP_D1;
    assign cap_data  = {POP_D1, POP_D1 ? D1_data_out : D0_data_out};
    assign valid_out = (occ != '0);
    assign deq       = valid_out & sink_ready;
    assign data_out  = head[DATA_W-1:0];
    assign dest_out  = head[DATA_W];
    assign idle_cond = (occ == '0) && !inflight && D0_empty && D1_empty;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) state <= ST_RESET;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (init) begin
            state_nxt = ST_INIT;
        end else begin
            case (state)
                ST_RESET:  state_nxt = ST_INIT;
                ST_INIT:   state_nxt = ST_IDLE;
                ST_IDLE:   if (!D0_empty || !D1_empty) state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (idle_cond) state_nxt = ST_IDLE;
                default:   state_nxt = ST_RESET;
            endcase
        end
    end

    // Room check uses registered occupancy only, so sink_ready never reaches POP_x.
    always_comb begin
        idle   = (state == ST_IDLE);
        flush  = init || (state == ST_INIT) || (state == ST_RESET);
        run    = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !init;
        room   = (int'(occ) + int'(inflight)) <= (BUF_DEPTH - 1);
        pop_go = run && room && (!D0_empty || !D1_empty);
        gnt_d1 = !D1_empty && (D0_empty || (rr == CH_D0));
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            POP_D0 <= 1'b0;
            POP_D1 <= 1'b0;
            rr     <= CH_D0;
        end else begin
            POP_D0 <= pop_go && !gnt_d1;
            POP_D1 <= pop_go && gnt_d1;
            if (pop_go) rr <= gnt_d1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt_d0 <= '0;
            cnt_d1 <= '0;
        end else if (init || state == ST_INIT) begin
            cnt_d0 <= '0;
            cnt_d1 <= '0;
        end else if (deq) begin
            if (dest_out == CH_D1) cnt_d1 <= cnt_d1 + CNT_W'(1);
            else                   cnt_d0 <= cnt_d0 + CNT_W'(1);
        end
    end

    pop_skid_buf #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .RESET_L   (RESET_L),
        .flush     (flush),
        .push      (inflight),
        .push_data (cap_data),
        .pop       (deq),
        .occ       (occ),
        .head      (head)
    );

endmodule

// File: tb/tb_d_pop_arbiter.sv
// Directed plus random bench for d_pop_arbiter against a queue-based reference model.
module tb_d_pop_arbiter;
    localparam int DW    = 6;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          RESET_L, init, D0_empty, D1_empty, sink_ready;
    logic [DW-1:0] D0_data_out, D1_data_out, data_out;
    logic          POP_D0, POP_D1, dest_out, valid_out, idle;
    logic [4:0]    cnt_d0, cnt_d1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    d_pop_arbiter dut (
        .clk(clk), .RESET_L(RESET_L), .init(init),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .sink_ready(sink_ready), .POP_D0(POP_D0), .POP_D1(POP_D1),
        .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
        .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
    );

    // Environment FIFOs: show-ahead, a word leaves at the edge that closes its pop strobe.
    logic [DW-1:0] f0[$], f1[$];
    bit            pend0 = 0, pend1 = 0;
    bit            init_on_pop1 = 0;
    int            pops0 = 0;
    logic [DW:0]   log_q[$];

    // Reference model: state 0..3 = RESET/INIT/IDLE/ACTIVE, buffer as a queue of {ch,data}.
    int            mstate = 0, mrr = 0, mcnt0 = 0, mcnt1 = 0;
    bit            mpop0 = 0, mpop1 = 0;
    logic [DW:0]   mbuf[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("pop_d0", POP_D0, mpop0);
        chk("pop_d1", POP_D1, mpop1);
        chk("valid_out", valid_out, mbuf.size() > 0);
        if (mbuf.size() > 0) chk("head", {dest_out, data_out}, mbuf[0]);
        chk("cnt_d0", cnt_d0, mcnt0);
        chk("cnt_d1", cnt_d1, mcnt1);
        chk("idle", idle, mstate == 2);
    endtask

    task automatic model_step();
        bit deq, room, run, el0, el1, g1, np0, np1, ic;
        int nxt;
        deq  = (mbuf.size() > 0) && sink_ready;
        room = (mbuf.size() + int'(mpop0 | mpop1)) <= DEPTH - 1;
        run  = (mstate == 2 || mstate == 3) && !init;
        el0  = !D0_empty;
        el1  = !D1_empty;
        np0  = 0;
        np1  = 0;
        if (run && room && (el0 || el1)) begin
            g1  = (el0 && el1) ? (mrr == 0) : el1;
            mrr = int'(g1);
            np1 = g1;
            np0 = !g1;
        end
        ic = (mbuf.size() == 0) && !(mpop0 || mpop1) && D0_empty && D1_empty;
        case (mstate)
            0:       nxt = 1;
            1:       nxt = 2;
            2:       nxt = (el0 || el1) ? 3 : 2;
            default: nxt = ic ? 2 : 3;
        endcase
        if (init) nxt = 1;
        if (init || mstate <= 1) begin
            mbuf.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            if (deq) begin
                if (mbuf[0][DW]) mcnt1 = (mcnt1 + 1) % 32;
                else             mcnt0 = (mcnt0 + 1) % 32;
                void'(mbuf.pop_front());
            end
            if (mpop0 || mpop1) mbuf.push_back({mpop1, mpop1 ? D1_data_out : D0_data_out});
        end
        mpop0  = np0;
        mpop1  = np1;
        mstate = nxt;
    endtask

    task automatic cyc(input bit i_init, input bit srdy);
        @(negedge clk);
        compare_all();
        pops0 += int'(POP_D0);
        if (pend0 && f0.size() > 0) void'(f0.pop_front());
        if (pend1 && f1.size() > 0) void'(f1.pop_front());
        pend0       = POP_D0;
        pend1       = POP_D1;
        init        = i_init || (init_on_pop1 && POP_D1);
        sink_ready  = srdy;
        D0_data_out = (f0.size() > 0) ? f0[0] : '0;
        D1_data_out = (f1.size() > 0) ? f1[0] : '0;
        D0_empty    = (f0.size() - int'(pend0)) <= 0;
        D1_empty    = (f1.size() - int'(pend1)) <= 0;
        if (valid_out && sink_ready) log_q.push_back({dest_out, data_out});
        @(posedge clk);
        model_step();
    endtask

    initial begin
        RESET_L = 0; init = 0; sink_ready = 0;
        D0_empty = 1; D1_empty = 1; D0_data_out = '0; D1_data_out = '0;
        #12;
        chk("rst_pop_d0", POP_D0, 0);
        chk("rst_pop_d1", POP_D1, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", {dest_out, data_out}, 0);
        chk("rst_cnt", {cnt_d1, cnt_d0}, 0);
        chk("rst_idle", idle, 0);
        @(negedge clk);
        RESET_L = 1;
        @(posedge clk);
        model_step();

        // init pulse, then idle
        cyc(1, 1); cyc(0, 1); cyc(0, 1);
        #1 chk("idle_after_init", idle, 1);

        // single D0 word
        log_q.delete();
        f0.push_back(6'b001010);
        repeat (8) cyc(0, 1);
        #1;
        chk("single_n", log_q.size(), 1);
        if (log_q.size() > 0) chk("single_word", log_q[0], {1'b0, 6'b001010});
        chk("single_cnt_d0", cnt_d0, 1);
        chk("single_idle", idle, 1);

        // both channels at once: rr=0 grants D1 first
        cyc(1, 1); cyc(0, 1); cyc(0, 1);
        log_q.delete();
        f0.push_back(6'b001010);
        f1.push_back(6'b111110);
        repeat (10) cyc(0, 1);
        #1;
        chk("rr_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("rr_first", log_q[0], {1'b1, 6'b111110});
            chk("rr_second", log_q[1], {1'b0, 6'b001010});
        end
        chk("rr_cnt_d0", cnt_d0, 1);
        chk("rr_cnt_d1", cnt_d1, 1);

        // backpressure: buffer stops at 3 words
        pops0 = 0;
        for (int i = 1; i <= 4; i++) f0.push_back(DW'(i));
        repeat (8) cyc(0, 0);
        #1;
        chk("bp_pops", pops0, 3);
        chk("bp_pop_low", POP_D0, 0);
        chk("bp_full_valid", valid_out, 1);
        log_q.delete();
        repeat (8) cyc(0, 1);
        #1;
        chk("bp_n", log_q.size(), 4);
        if (log_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_order", log_q[i], {1'b0, DW'(i + 1)});

        // init during a D1 pop strobe discards the in-flight word
        f1.push_back(6'b010101);
        init_on_pop1 = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1);
            if (init) break;
        end
        init_on_pop1 = 0;
        #1;
        chk("inflight_init_seen", init, 1);
        chk("inflight_valid", valid_out, 0);
        chk("inflight_cnt", {cnt_d1, cnt_d0}, 0);
        chk("inflight_idle", idle, 0);
        repeat (3) cyc(0, 1);

        // counter wrap: 33 D1 words
        log_q.delete();
        for (int i = 0; i < 33; i++) f1.push_back(DW'(i));
        repeat (45) cyc(0, 1);
        #1;
        chk("wrap_n", log_q.size(), 33);
        chk("wrap_cnt_d1", cnt_d1, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (f0.size() < 6 && $urandom_range(0, 2) == 0) f0.push_back(DW'($urandom));
            if (f1.size() < 6 && $urandom_range(0, 2) == 0) f1.push_back(DW'($urandom));
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
